// File: rtl/cgra_bank_arb_pkg.sv
// Shared constants and request type for the CGRA bank arbiter.
// Defining CGRA_BANK_ARB_RSP_REG_EN selects the two-cycle response path.
package cgra_bank_arb_pkg;

    localparam int MAX_PORTS   = 8;
    localparam int BANK_ADDR_W = 16;

`ifdef CGRA_BANK_ARB_RSP_REG_EN
    localparam int RSP_LATENCY = 2;
`else
    localparam int RSP_LATENCY = 1;
`endif

    typedef struct packed {
        logic                   we;
        logic [BANK_ADDR_W-1:0] addr;
        logic [31:0]            wdata;
        logic [3:0]             be;
    } bank_req_t;

    function automatic bank_req_t bank_req_idle();
        bank_req_t req_v;
        req_v = '0;
        return req_v;
    endfunction

endpackage

// File: rtl/cgra_rr_arbiter.sv
// Generic round-robin one-hot arbiter; the pointer moves one past the last
// granted port and holds when nothing is requested.
module cgra_rr_arbiter
    import cgra_bank_arb_pkg::*;
#(
    parameter  int NumPorts = 4,
    localparam int PtrWidth = $clog2(NumPorts)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumPorts-1:0] req_i,
    output logic [NumPorts-1:0] gnt_o,
    output logic [PtrWidth-1:0] gnt_idx_o,
    output logic                gnt_valid_o
);

    logic [PtrWidth-1:0] ptr_r;
    logic [PtrWidth-1:0] ptr_nxt_s;
    logic [NumPorts-1:0] gnt_s;
    logic [PtrWidth-1:0] idx_s;
    logic                found_s;

    // Scan upward from the pointer, wrapping past the last port; reset blocks all grants.
    always_comb begin
        logic [PtrWidth:0] cand_v;
        gnt_s   = '0;
        idx_s   = '0;
        found_s = 1'b0;
        cand_v  = '0;
        if (rst_i) begin
            gnt_s   = '0;
            found_s = 1'b0;
        end else begin
            for (int i = 0; i < MAX_PORTS; i++) begin
                if (i < NumPorts) begin
                    cand_v = {1'b0, ptr_r} + (PtrWidth+1)'(i);
                    if (cand_v >= (PtrWidth+1)'(NumPorts)) begin
                        cand_v = cand_v - (PtrWidth+1)'(NumPorts);
                    end else begin
                        cand_v = cand_v;
                    end
                    if (!found_s && req_i[cand_v[PtrWidth-1:0]]) begin
                        found_s                     = 1'b1;
                        idx_s                       = cand_v[PtrWidth-1:0];
                        gnt_s[cand_v[PtrWidth-1:0]] = 1'b1;
                    end else begin
                        found_s = found_s;
                    end
                end else begin
                    cand_v = cand_v;
                end
            end
        end
    end

    // Next pointer: one past the winner, modulo the port count.
    always_comb begin
        ptr_nxt_s = ptr_r;
        if (found_s) begin
            if (idx_s == PtrWidth'(NumPorts - 1)) begin
                ptr_nxt_s = '0;
            end else begin
                ptr_nxt_s = idx_s + PtrWidth'(1);
            end
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_r <= '0;
        end else begin
            ptr_r <= ptr_nxt_s;
        end
    end

    assign gnt_o       = gnt_s;
    assign gnt_idx_o   = idx_s;
    assign gnt_valid_o = found_s;

endmodule

// File: rtl/cgra_bank_arbiter.sv
// Request-side arbiter in front of one single-ported CGRA SRAM bank.
// Optional macro CGRA_BANK_ARB_RSP_REG_EN adds a response register stage (latency 2).
module cgra_bank_arbiter
    import cgra_bank_arb_pkg::*;
#(
    parameter  int NumPorts  = 4,
    parameter  int NumWords  = 1024,
    localparam int AddrWidth = $clog2(NumWords),
    localparam int PtrWidth  = $clog2(NumPorts)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumPorts-1:0]           req_i,
    input  logic [NumPorts-1:0]           we_i,
    input  logic [NumPorts*AddrWidth-1:0] addr_i,
    input  logic [NumPorts*32-1:0]        wdata_i,
    input  logic [NumPorts*4-1:0]         be_i,
    output logic [NumPorts-1:0]           gnt_o,
    output logic [NumPorts-1:0]           rvalid_o,
    output logic [31:0]                   rdata_o,
    output logic                          sram_req_o,
    output logic                          sram_we_o,
    output logic [AddrWidth-1:0]          sram_addr_o,
    output logic [31:0]                   sram_wdata_o,
    output logic [3:0]                    sram_be_o,
    output logic                          sram_set_retentive_no,
    input  logic [31:0]                   sram_rdata_i
);

    bank_req_t           port_req_s [NumPorts];
    bank_req_t           sel_s;
    logic [NumPorts-1:0] gnt_s;
    logic [PtrWidth-1:0] gnt_idx_s;
    logic                gnt_valid_s;
    logic [NumPorts-1:0] rvalid1_r;
    logic                rd1_r;
    logic [NumPorts-1:0] rsp_valid_s;
    logic [31:0]         rsp_data_s;

    cgra_rr_arbiter #(
        .NumPorts(NumPorts)
    ) u_rr_arbiter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .gnt_o      (gnt_s),
        .gnt_idx_o  (gnt_idx_s),
        .gnt_valid_o(gnt_valid_s)
    );

    for (genvar k = 0; k < NumPorts; k++) begin : g_port_unpack
        assign port_req_s[k] = '{
            we:    we_i[k],
            addr:  BANK_ADDR_W'(addr_i[k*AddrWidth +: AddrWidth]),
            wdata: wdata_i[k*32 +: 32],
            be:    be_i[k*4 +: 4]
        };
    end

    // The bank field is wider than any legal address; the pad is zero by construction.
    if (AddrWidth < BANK_ADDR_W) begin : g_addr_pad
        logic [BANK_ADDR_W-AddrWidth-1:0] addr_pad_unused_s;
        assign addr_pad_unused_s = sel_s.addr[BANK_ADDR_W-1:AddrWidth];
    end

    // Route the granted port's payload to the bank; park the bus at zero when idle.
    always_comb begin
        sel_s = bank_req_idle();
        if (gnt_valid_s) begin
            sel_s = port_req_s[gnt_idx_s];
        end else begin
            sel_s = bank_req_idle();
        end
    end

    // Bank request strobe, suppressed during reset.
    always_comb begin
        sram_req_o = 1'b0;
        if (rst_i) begin
            sram_req_o = 1'b0;
        end else begin
            sram_req_o = |req_i;
        end
    end

    assign gnt_o                 = gnt_s;
    assign sram_we_o             = sel_s.we;
    assign sram_addr_o           = sel_s.addr[AddrWidth-1:0];
    assign sram_wdata_o          = sel_s.wdata;
    assign sram_be_o             = sel_s.be;
    assign sram_set_retentive_no = 1'b1;

    // First response stage: which port was accepted and whether it was a read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid1_r <= '0;
            rd1_r     <= 1'b0;
        end else begin
            rvalid1_r <= gnt_s & req_i;
            rd1_r     <= gnt_valid_s & ~sel_s.we;
        end
    end

    if (RSP_LATENCY == 2) begin : g_rsp_reg
        logic [NumPorts-1:0] rvalid2_r;
        logic [31:0]         rdata2_r;

        // Second response stage: capture bank data so the response leaves from flops.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rvalid2_r <= '0;
                rdata2_r  <= 32'h0000_0000;
            end else begin
                rvalid2_r <= rvalid1_r;
                rdata2_r  <= rd1_r ? sram_rdata_i : 32'h0000_0000;
            end
        end

        assign rsp_valid_s = rvalid2_r;
        assign rsp_data_s  = rdata2_r;
    end else begin : g_rsp_direct
        assign rsp_valid_s = rvalid1_r;
        assign rsp_data_s  = rd1_r ? sram_rdata_i : 32'h0000_0000;
    end

    // A response still in flight when reset arrives is dropped, not delivered.
    always_comb begin
        rvalid_o = '0;
        rdata_o  = 32'h0000_0000;
        if (rst_i) begin
            rvalid_o = '0;
            rdata_o  = 32'h0000_0000;
        end else begin
            rvalid_o = rsp_valid_s;
            rdata_o  = rsp_data_s;
        end
    end

endmodule

// File: tb/tb_cgra_bank_arbiter.sv
// Table-driven bench for cgra_bank_arbiter with a behavioural bank and a
// response scoreboard queue.
module tb_cgra_bank_arbiter;

    localparam int NP = 4;
    localparam int AW = 10;
`ifdef CGRA_BANK_ARB_RSP_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int NVEC = 29;

    logic           clk = 1'b0;
    logic           rst_i;
    logic [NP-1:0]  req_i;
    logic [NP-1:0]  we_i;
    logic [NP*AW-1:0] addr_i;
    logic [NP*32-1:0] wdata_i;
    logic [NP*4-1:0]  be_i;
    logic [NP-1:0]  gnt_o;
    logic [NP-1:0]  rvalid_o;
    logic [31:0]    rdata_o;
    logic           sram_req_o;
    logic           sram_we_o;
    logic [AW-1:0]  sram_addr_o;
    logic [31:0]    sram_wdata_o;
    logic [3:0]     sram_be_o;
    logic           sram_set_retentive_no;
    logic [31:0]    sram_rdata_i;

    logic [31:0]    bank_mem [1024];
    int             n_tests = 0;
    int             n_fail  = 0;

    typedef struct {
        logic          pre_rst;
        logic [NP-1:0] req;
        logic [NP-1:0] we;
        logic [NP*AW-1:0] addr;
        logic [NP*32-1:0] wdata;
        logic [NP*4-1:0]  be;
        logic [NP-1:0] exp_gnt;
        logic [31:0]   exp_rdata;
    } vec_t;

    typedef struct {
        logic [NP-1:0] valid;
        logic [31:0]   data;
    } rsp_t;

    rsp_t sb[$];
    vec_t vecs[NVEC];

    cgra_bank_arbiter #(.NumPorts(NP), .NumWords(1024)) dut (
        .clk_i                (clk),
        .rst_i                (rst_i),
        .req_i                (req_i),
        .we_i                 (we_i),
        .addr_i               (addr_i),
        .wdata_i              (wdata_i),
        .be_i                 (be_i),
        .gnt_o                (gnt_o),
        .rvalid_o             (rvalid_o),
        .rdata_o              (rdata_o),
        .sram_req_o           (sram_req_o),
        .sram_we_o            (sram_we_o),
        .sram_addr_o          (sram_addr_o),
        .sram_wdata_o         (sram_wdata_o),
        .sram_be_o            (sram_be_o),
        .sram_set_retentive_no(sram_set_retentive_no),
        .sram_rdata_i         (sram_rdata_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    // Behavioural single-ported bank with one-cycle read latency.
    always @(posedge clk) begin
        if (sram_req_o && sram_we_o) begin
            bank_mem[sram_addr_o] <= merge_be(bank_mem[sram_addr_o], sram_wdata_o, sram_be_o);
        end else if (sram_req_o) begin
            sram_rdata_i <= bank_mem[sram_addr_o];
        end
    end

    function automatic vec_t junk_vec();
        vec_t v;
        v.pre_rst   = 1'b0;
        v.req       = '0;
        v.exp_gnt   = '0;
        v.exp_rdata = 32'h0;
        for (int k = 0; k < NP; k++) begin
            v.we[k]               = k[0];
            v.addr[k*AW +: AW]    = 10'h3F0 + 10'(k);
            v.wdata[k*32 +: 32]   = 32'hBAD0_0000 + 32'(k);
            v.be[k*4 +: 4]        = 4'hA ^ 4'(k);
        end
        return v;
    endfunction

    function automatic vec_t single(input int p, input logic w, input logic [AW-1:0] a,
                                    input logic [31:0] d, input logic [3:0] b,
                                    input logic [31:0] er);
        vec_t v;
        v = junk_vec();
        v.req[p]            = 1'b1;
        v.we[p]             = w;
        v.addr[p*AW +: AW]  = a;
        v.wdata[p*32 +: 32] = d;
        v.be[p*4 +: 4]      = b;
        v.exp_gnt[p]        = 1'b1;
        v.exp_rdata         = er;
        return v;
    endfunction

    function automatic vec_t multi(input logic [NP-1:0] mask, input logic [NP-1:0] eg);
        vec_t v;
        v = junk_vec();
        v.req     = mask;
        v.exp_gnt = eg;
        for (int k = 0; k < NP; k++) begin
            v.we[k]             = 1'b1;
            v.addr[k*AW +: AW]  = 10'h100 + 10'(k);
            v.wdata[k*32 +: 32] = 32'hC0DE_0000 + 32'(k);
            v.be[k*4 +: 4]      = 4'hF;
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        rsp_t e;
        int   pi;
        req_i   = v.req;
        we_i    = v.we;
        addr_i  = v.addr;
        wdata_i = v.wdata;
        be_i    = v.be;
        #1;
        check("gnt", 32'(gnt_o), 32'(v.exp_gnt));
        check("sram_req", 32'(sram_req_o), 32'(|v.req));
        pi = -1;
        for (int k = 0; k < NP; k++) begin
            if (v.exp_gnt[k]) pi = k;
        end
        if (pi >= 0) begin
            check("sram_we", 32'(sram_we_o), 32'(v.we[pi]));
            check("sram_addr", 32'(sram_addr_o), 32'(v.addr[pi*AW +: AW]));
            check("sram_wdata", sram_wdata_o, v.wdata[pi*32 +: 32]);
            check("sram_be", 32'(sram_be_o), 32'(v.be[pi*4 +: 4]));
        end else begin
            check("idle_bus", {sram_wdata_o[15:0], 6'(sram_addr_o), sram_be_o, 5'(sram_we_o)}, 32'h0);
        end
        if (sb.size() >= LAT) begin
            e = sb.pop_front();
        end else begin
            e.valid = '0;
            e.data  = 32'h0;
        end
        check("rvalid", 32'(rvalid_o), 32'(e.valid));
        check("rdata", rdata_o, e.data);
        e.valid = v.exp_gnt;
        e.data  = v.exp_rdata;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [NP-1:0] rq);
        rst_i = 1'b1;
        req_i = rq;
        #1;
        check("rst_gnt", 32'(gnt_o), 32'h0);
        check("rst_sram_req", 32'(sram_req_o), 32'h0);
        check("rst_sram_bus", {sram_wdata_o[15:0], 6'(sram_addr_o), sram_be_o, 5'(sram_we_o)}, 32'h0);
        check("rst_rvalid", 32'(rvalid_o), 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        req_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t idle_v;
        for (int i = 0; i < 1024; i++) bank_mem[i] = 32'h0;
        sram_rdata_i = 32'h0;
        rst_i   = 1'b1;
        req_i   = '0;
        we_i    = '1;
        addr_i  = '1;
        wdata_i = '1;
        be_i    = '1;
        idle_v  = junk_vec();

        vecs[0]  = single(2, 1'b1, 10'h010, 32'hDEAD_BEEF, 4'hF, 32'h0);
        vecs[1]  = single(2, 1'b0, 10'h010, 32'h0, 4'hF, 32'hDEAD_BEEF);
        vecs[2]  = single(1, 1'b1, 10'h020, 32'h1122_3344, 4'hF, 32'h0);
        vecs[3]  = single(1, 1'b1, 10'h020, 32'hAABB_CCDD, 4'b0101, 32'h0);
        vecs[4]  = single(1, 1'b0, 10'h020, 32'h0, 4'hF, 32'h11BB_33DD);
        vecs[5]  = idle_v;
        vecs[6]  = idle_v;
        vecs[7]  = multi(4'hF, 4'b0001);
        vecs[7].pre_rst = 1'b1;
        vecs[8]  = multi(4'hF, 4'b0010);
        vecs[9]  = multi(4'hF, 4'b0100);
        vecs[10] = multi(4'hF, 4'b1000);
        vecs[11] = multi(4'hF, 4'b0001);
        vecs[12] = multi(4'hF, 4'b0010);
        vecs[13] = multi(4'hF, 4'b0100);
        vecs[14] = multi(4'hF, 4'b1000);
        vecs[15] = single(2, 1'b1, 10'h030, 32'h0000_0001, 4'hF, 32'h0);
        vecs[16] = multi(4'b1010, 4'b1000);
        vecs[17] = multi(4'b1010, 4'b0010);
        vecs[18] = multi(4'b1010, 4'b1000);
        vecs[19] = single(3, 1'b0, 10'h103, 32'h0, 4'hF, 32'hC0DE_0003);
        vecs[20] = single(0, 1'b0, 10'h102, 32'h0, 4'hF, 32'hC0DE_0002);
        for (int i = 0; i < 4; i++) begin
            vecs[21+i] = single(0, 1'b1, 10'(i), 32'h5000_0000 + 32'(i), 4'hF, 32'h0);
            vecs[25+i] = single(0, 1'b0, 10'(i), 32'h0, 4'hF, 32'h5000_0000 + 32'(i));
        end

        do_reset(4'hF);
        check("retentive", 32'(sram_set_retentive_no), 32'h1);

        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].pre_rst) do_reset(4'hF);
            apply(vecs[i]);
        end
        for (int i = 0; i < LAT; i++) apply(idle_v);

        // Reset in the cycle after a port-0 read grant: response dropped, pointer back to 0.
        apply(single(0, 1'b0, 10'h001, 32'h0, 4'hF, 32'h5000_0001));
        do_reset(4'hF);
        apply(multi(4'hF, 4'b0001));
        apply(multi(4'hF, 4'b0010));
        for (int i = 0; i < LAT; i++) apply(idle_v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
